// File: rtl/s_axis_cc_adapt_pkg.sv
// s_axis_cc_adapt_pkg
//   Shared constants for the UltraScale completer-completion adapter:
//   - bit offsets of the legacy 3DW completion header fields (L0..L2)
//   - bit offsets of the UltraScale CC descriptor fields (D0..D2)
//   - completion type code, 4 KiB byte count and maximum dword count
//   - popcount helper used by the length checker
package s_axis_cc_adapt_pkg;

  // Dword base positions of the header inside the first data beat
  localparam int L0_BASE = 0;
  localparam int L1_BASE = 32;
  localparam int L2_BASE = 64;

  // Legacy header, DW0
  localparam int L0_LEN_LSB      = 0;
  localparam int L0_ATTR_LSB     = 12;
  localparam int L0_EP_BIT       = 14;
  localparam int L0_TC_LSB       = 20;
  localparam int L0_TYPE_LSB     = 24;
  localparam int L0_HAS_DATA_BIT = 30;

  // Legacy header, DW1
  localparam int L1_BC_LSB     = 0;
  localparam int L1_STATUS_LSB = 13;
  localparam int L1_CPL_ID_LSB = 16;

  // Legacy header, DW2
  localparam int L2_LADDR_LSB  = 0;
  localparam int L2_TAG_LSB    = 8;
  localparam int L2_REQ_ID_LSB = 16;

  // CC descriptor, DW0
  localparam int D0_LADDR_LSB  = 0;
  localparam int D0_AT_LSB     = 8;
  localparam int D0_BC_LSB     = 16;
  localparam int D0_LOCKED_BIT = 29;

  // CC descriptor, DW1
  localparam int D1_DWCNT_LSB  = 0;
  localparam int D1_STATUS_LSB = 11;
  localparam int D1_EP_BIT     = 14;
  localparam int D1_REQ_ID_LSB = 16;

  // CC descriptor, DW2
  localparam int D2_TAG_LSB       = 0;
  localparam int D2_CPL_ID_LSB    = 8;
  localparam int D2_CPL_ID_EN_BIT = 24;
  localparam int D2_TC_LSB        = 25;
  localparam int D2_ATTR_LSB      = 28;

  localparam logic [4:0]  CPLLK        = 5'h0B;
  localparam logic [12:0] BYTECOUNT_4K = 13'h1000;
  localparam logic [10:0] MAX_DWCNT    = 11'd1024;

  // Three header dwords, DW0 in the low bits
  typedef struct packed {
    logic [31:0] dw2;
    logic [31:0] dw1;
    logic [31:0] dw0;
  } hdr3_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/s_axis_cc_adapt_skid.sv
// axis_skid_buf
//   Two-entry output buffer for an AXI-Stream style channel. One cycle of
//   latency, full throughput, and a registered upstream ready that drops
//   only when both entries hold data. The head entry is held stable while
//   the downstream side stalls.
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_data, i_valid    upstream beat
//   o_ready            upstream ready (registered)
//   o_data, o_valid    downstream beat
//   i_ready            downstream ready
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             r_ready;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;

  assign w_push = i_valid & r_ready;
  assign w_pop  = (r_count != 2'd0) & i_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= w_count_nxt;
      // Ready is a pure register: it looks ahead at next cycle's occupancy.
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_valid = (r_count != 2'd0);
  assign o_ready = r_ready;

endmodule

// File: rtl/s_axis_cc_adapt.sv
// s_axis_cc_adapt
//   Converts legacy 7-series 3DW completion TLPs into UltraScale CC
//   descriptor format. The header beat has its first three dwords rewritten.
//   Payload passes through unchanged, since it is DW3-aligned on both sides.
//   The number of dwords in the packet is checked against the header length.
//   A mismatch marks the last beat as discontinued and pulses cc_len_err.
// Ports
//   user_clk, user_reset               clock, asynchronous active-high reset
//   s_axis_cc_t{data,keep,last,valid}  legacy completion stream in
//   s_axis_cc_tready                   legacy ready, replicated on 4 bits
//   s_axis_cc_tuser                    ignored
//   s_axis_cc_t{data,keep,last}_a      IP-side stream, dword keep
//   s_axis_cc_tvalid_a/_tready_a       IP-side handshake (ready bit 0 only)
//   s_axis_cc_tuser_a                  [0] discontinue, parity bits zero
//   cc_len_err                         length mismatch, seen at input accept
//
// state   | meaning
// HDR     | next accepted beat carries the 3DW header
// BODY    | inside a packet, beats pass through
module s_axis_cc_adapt
  import s_axis_cc_adapt_pkg::*;
#(
  parameter int   DATA_WIDTH      = 128,
  parameter int   KEEP_WIDTH      = DATA_WIDTH/8,
  parameter logic COMPLETER_ID_EN = 1'b0
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic [DATA_WIDTH-1:0]   s_axis_cc_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_cc_tkeep,
  input  logic                    s_axis_cc_tlast,
  input  logic                    s_axis_cc_tvalid,
  output logic [3:0]              s_axis_cc_tready,
  input  logic [3:0]              s_axis_cc_tuser,
  output logic [DATA_WIDTH-1:0]   s_axis_cc_tdata_a,
  output logic [KEEP_WIDTH/4-1:0] s_axis_cc_tkeep_a,
  output logic                    s_axis_cc_tlast_a,
  output logic                    s_axis_cc_tvalid_a,
  input  logic [3:0]              s_axis_cc_tready_a,
  output logic [32:0]             s_axis_cc_tuser_a,
  output logic                    cc_len_err
);

  localparam int NDW    = KEEP_WIDTH/4;
  localparam int SKID_W = DATA_WIDTH + NDW + 2;

  localparam logic [0:0] ST_HDR  = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  logic [0:0]            r_state;
  logic [10:0]           r_dw_cnt;
  logic [10:0]           r_exp_dws;

  logic                  w_tready;
  logic                  w_accept;
  logic [12:0]           w_bytecnt;
  logic [10:0]           w_dwcnt;
  hdr3_t                 w_desc;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NDW-1:0]        w_keep_a;
  logic [7:0]            w_keep8;
  logic [3:0]            w_beat_dws;
  logic [10:0]           w_base;
  logic [10:0]           w_total;
  logic [10:0]           w_exp;
  logic                  w_mismatch;
  logic [SKID_W-1:0]     w_skid_in;
  logic [SKID_W-1:0]     w_skid_out;
  logic                  w_discont_a;
  logic                  w_unused_ok;

  assign w_accept         = s_axis_cc_tvalid & w_tready;
  assign s_axis_cc_tready = {4{w_tready}};

  // Header field decode. Only meaningful on the HDR beat.
  always_comb begin
    w_bytecnt = (s_axis_cc_tdata[L1_BASE + L1_BC_LSB +: 12] == 12'h000)
                ? BYTECOUNT_4K
                : {1'b0, s_axis_cc_tdata[L1_BASE + L1_BC_LSB +: 12]};
    if (!s_axis_cc_tdata[L0_BASE + L0_HAS_DATA_BIT])
      w_dwcnt = 11'd0;
    else if (s_axis_cc_tdata[L0_BASE + L0_LEN_LSB +: 10] == 10'd0)
      w_dwcnt = MAX_DWCNT;
    else
      w_dwcnt = {1'b0, s_axis_cc_tdata[L0_BASE + L0_LEN_LSB +: 10]};
  end

  always_comb begin
    w_desc = '0;
    w_desc.dw0[D0_LADDR_LSB +: 7]  = s_axis_cc_tdata[L2_BASE + L2_LADDR_LSB +: 7];
    w_desc.dw0[D0_AT_LSB +: 2]     = 2'b00;
    w_desc.dw0[D0_BC_LSB +: 13]    = w_bytecnt;
    w_desc.dw0[D0_LOCKED_BIT]      = (s_axis_cc_tdata[L0_BASE + L0_TYPE_LSB +: 5] == CPLLK);
    w_desc.dw1[D1_DWCNT_LSB +: 11] = w_dwcnt;
    w_desc.dw1[D1_STATUS_LSB +: 3] = s_axis_cc_tdata[L1_BASE + L1_STATUS_LSB +: 3];
    w_desc.dw1[D1_EP_BIT]          = s_axis_cc_tdata[L0_BASE + L0_EP_BIT];
    w_desc.dw1[D1_REQ_ID_LSB +: 16] = s_axis_cc_tdata[L2_BASE + L2_REQ_ID_LSB +: 16];
    w_desc.dw2[D2_TAG_LSB +: 8]    = s_axis_cc_tdata[L2_BASE + L2_TAG_LSB +: 8];
    w_desc.dw2[D2_CPL_ID_LSB +: 16] = s_axis_cc_tdata[L1_BASE + L1_CPL_ID_LSB +: 16];
    w_desc.dw2[D2_CPL_ID_EN_BIT]   = COMPLETER_ID_EN;
    w_desc.dw2[D2_TC_LSB +: 3]     = s_axis_cc_tdata[L0_BASE + L0_TC_LSB +: 3];
    w_desc.dw2[D2_ATTR_LSB +: 3]   = {1'b0, s_axis_cc_tdata[L0_BASE + L0_ATTR_LSB +: 2]};
  end

  always_comb begin
    w_data = s_axis_cc_tdata;
    if (r_state == ST_HDR) w_data[95:0] = w_desc;
  end

  // Legacy keep is per byte; the IP side wants one bit per dword.
  always_comb begin
    w_keep_a = '0;
    for (int i = 0; i < NDW; i++) w_keep_a[i] = s_axis_cc_tkeep[4*i];
  end

  always_comb begin
    w_keep8 = '0;
    w_keep8[NDW-1:0] = w_keep_a;
  end

  assign w_beat_dws = popcount8(w_keep8);

  // On the header beat the running count restarts and the expected length
  // comes straight from the header being accepted; afterwards it is latched.
  assign w_base     = (r_state == ST_HDR) ? 11'd0 : r_dw_cnt;
  assign w_total    = w_base + {7'd0, w_beat_dws};
  assign w_exp      = (r_state == ST_HDR) ? (11'd3 + w_dwcnt) : r_exp_dws;
  assign w_mismatch = s_axis_cc_tlast & (w_total != w_exp);
  assign cc_len_err = w_accept & w_mismatch;

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      r_state   <= ST_HDR;
      r_dw_cnt  <= 11'd0;
      r_exp_dws <= 11'd0;
    end else if (w_accept) begin
      if (s_axis_cc_tlast) begin
        r_state  <= ST_HDR;
        r_dw_cnt <= 11'd0;
      end else begin
        r_state   <= ST_BODY;
        r_dw_cnt  <= w_total;
        r_exp_dws <= w_exp;
      end
    end
  end

  assign w_skid_in = {w_data, w_keep_a, s_axis_cc_tlast, w_mismatch};

  axis_skid_buf #(
    .WIDTH (SKID_W)
  ) u_skid (
    .i_clk   (user_clk),
    .i_rst   (user_reset),
    .i_data  (w_skid_in),
    .i_valid (s_axis_cc_tvalid),
    .o_ready (w_tready),
    .o_data  (w_skid_out),
    .o_valid (s_axis_cc_tvalid_a),
    .i_ready (s_axis_cc_tready_a[0])
  );

  assign {s_axis_cc_tdata_a, s_axis_cc_tkeep_a, s_axis_cc_tlast_a, w_discont_a} = w_skid_out;
  assign s_axis_cc_tuser_a = {32'd0, w_discont_a};

  assign w_unused_ok = ^{s_axis_cc_tuser, s_axis_cc_tready_a[3:1], s_axis_cc_tkeep};

endmodule
